// File: rtl/nibble_pkg.sv
// Shared opcodes, state encoding and decode helpers for the nibble sequencer.
package nibble_pkg;

  localparam logic [3:0] OP_JC   = 4'h8;
  localparam logic [3:0] OP_JNC  = 4'h9;
  localparam logic [3:0] OP_JZ   = 4'hA;
  localparam logic [3:0] OP_JNZ  = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_NOP  = 4'hD;
  localparam logic [3:0] OP_WAIT = 4'hE;
  localparam logic [3:0] OP_HLT  = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_JUMP   = 3'd3,
    ST_WAIT   = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  function automatic logic is_jump(input logic [3:0] instr);
    return (instr >= OP_JC) && (instr <= OP_JMP);
  endfunction

endpackage

// File: rtl/jump_cond.sv
// Resolves whether a two-byte jump instruction is taken from the carry/zero flags.
module jump_cond
  import nibble_pkg::*;
(
  input  logic [3:0] instr,
  input  logic       c_flag,
  input  logic       z_flag,
  output logic       take
);

  always_comb begin
    take = 1'b0;
    case (instr)
      OP_JC:   take = c_flag;
      OP_JNC:  take = ~c_flag;
      OP_JZ:   take = z_flag;
      OP_JNZ:  take = ~z_flag;
      OP_JMP:  take = 1'b1;
      default: take = 1'b0;
    endcase
  end

endmodule

// File: rtl/nibble_sequencer.sv
// Fetch/decode/jump sequencer driving the PC, fetch register and ALU strobe.
module nibble_sequencer
  import nibble_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  program_byte,
  input  logic [3:0]  instr,
  input  logic [3:0]  oprnd,
  input  logic        c_flag,
  input  logic        z_flag,
  output logic        pc_en,
  output logic        pc_load,
  output logic [11:0] pc_d,
  output logic        fetch_en,
  output logic        alu_strobe,
  output logic [3:0]  alu_op,
  output logic [3:0]  alu_oprnd,
  output logic        halted,
  output logic [2:0]  phase
);

  state_t     state_q, state_d;
  logic [7:0] imm_q, imm_d;
  logic       take;

  jump_cond u_jumpCond (
    .instr  (instr),
    .c_flag (c_flag),
    .z_flag (z_flag),
    .take   (take)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      imm_q   <= '0;
    end else begin
      state_q <= state_d;
      imm_q   <= imm_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    imm_d      = imm_q;
    pc_en      = 1'b0;
    pc_load    = 1'b0;
    pc_d       = '0;
    fetch_en   = 1'b0;
    alu_strobe = 1'b0;
    alu_op     = '0;
    alu_oprnd  = '0;
    halted     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        fetch_en = 1'b1;
        pc_en    = 1'b1;
        state_d  = ST_DECODE;
      end
      ST_DECODE: begin
        // The PC already points at the second byte, so a jump grabs it straight off the ROM.
        if (!instr[3]) begin
          alu_strobe = 1'b1;
          alu_op     = instr;
          alu_oprnd  = oprnd;
          state_d    = ST_FETCH;
        end else if (is_jump(instr)) begin
          pc_en   = 1'b1;
          imm_d   = program_byte;
          state_d = ST_JUMP;
        end else if (instr == OP_NOP) begin
          state_d = ST_FETCH;
        end else if (instr == OP_WAIT) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_HALT;
        end
      end
      ST_JUMP: begin
        if (take) begin
          pc_load = 1'b1;
          pc_d    = {oprnd, imm_q};
        end
        state_d = ST_FETCH;
      end
      ST_WAIT: begin
        if (start) state_d = ST_FETCH;
      end
      ST_HALT: begin
        halted = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign phase = state_q;

endmodule
